// File: rtl/tx_packet_scheduler.sv
// Arbitrates the single outbound 40-bit monitor-link packet slot between power-on reply,
// keyboard/mouse and microphone sources, holds the packet until retrieved, then acks the winner.
module tx_packet_scheduler #(
    parameter logic [39:0] PWR_PKT   = 40'h0000000000,
    parameter logic [7:0]  KB_OP     = 8'h00,
    parameter logic [7:0]  MOUSE_OP  = 8'h00,
    parameter logic [7:0]  MIC_OP    = 8'h00,
    parameter int          KB_STARVE = 3,
    parameter logic [15:0] STALL_MAX = 16'd50000
) (
    input  logic        mon_clk,
    input  logic        hw_reset_n,
    input  logic        pwr_req,
    input  logic        kb_valid,
    input  logic        kb_is_mouse,
    input  logic [15:0] kb_data,
    output logic        kb_ack,
    input  logic        mic_valid,
    input  logic [31:0] mic_data,
    output logic        mic_ack,
    output logic [39:0] out_data,
    output logic        out_valid,
    input  logic        out_retrieved,
    output logic [1:0]  grant_src,
    output logic        stall_err
);

    localparam int SW = $clog2(KB_STARVE + 1);
    localparam logic [SW-1:0] STARVE_LIMIT = SW'(KB_STARVE);

    localparam logic [1:0] SRC_NONE = 2'd0;
    localparam logic [1:0] SRC_PWR  = 2'd1;
    localparam logic [1:0] SRC_KB   = 2'd2;
    localparam logic [1:0] SRC_MIC  = 2'd3;

    typedef enum logic [1:0] {IDLE, OFFER, ACK} state_t;

    state_t        state, state_next;
    logic          pwr_pending;
    logic [SW-1:0] starve_cnt;
    logic [15:0]   stall_cnt;
    logic [1:0]    win_src;
    logic [39:0]   win_pkt;
    logic          pwr_want;
    logic          kb_forced;

    // A pwr_req pulse competes in the same cycle it arrives, keeping reply latency at one cycle.
    assign pwr_want  = pwr_pending | pwr_req;
    assign kb_forced = kb_valid && (starve_cnt == STARVE_LIMIT);

    always_ff @(posedge mon_clk) begin
        if (!hw_reset_n) state <= IDLE;
        else             state <= state_next;
    end

    always_comb begin
        state_next = state;
        win_src    = SRC_NONE;
        win_pkt    = '0;
        case (state)
            IDLE: begin
                if (pwr_want)       win_src = SRC_PWR;
                else if (kb_forced) win_src = SRC_KB;
                else if (mic_valid) win_src = SRC_MIC;
                else if (kb_valid)  win_src = SRC_KB;
                if (win_src != SRC_NONE) state_next = OFFER;
            end
            OFFER:   if (out_retrieved) state_next = ACK;
            ACK:     state_next = IDLE;
            default: state_next = IDLE;
        endcase
        case (win_src)
            SRC_PWR: win_pkt = PWR_PKT;
            SRC_KB:  win_pkt = {kb_is_mouse ? MOUSE_OP : KB_OP, 16'h0000, kb_data};
            SRC_MIC: win_pkt = {MIC_OP, mic_data};
            default: win_pkt = '0;
        endcase
    end

    assign kb_ack  = (state == ACK) && (grant_src == SRC_KB);
    assign mic_ack = (state == ACK) && (grant_src == SRC_MIC);

    always_ff @(posedge mon_clk) begin
        if (!hw_reset_n) begin
            out_data    <= '0;
            out_valid   <= 1'b0;
            grant_src   <= SRC_NONE;
            stall_err   <= 1'b0;
            pwr_pending <= 1'b0;
            starve_cnt  <= '0;
            stall_cnt   <= '0;
        end else begin
            // A request landing on the clearing cycle re-arms, so the reply goes out again.
            if (state == ACK && grant_src == SRC_PWR) pwr_pending <= pwr_req;
            else                                      pwr_pending <= pwr_pending | pwr_req;

            case (state)
                IDLE: begin
                    if (win_src != SRC_NONE) begin
                        out_data  <= win_pkt;
                        grant_src <= win_src;
                        out_valid <= 1'b1;
                        stall_cnt <= '0;
                    end
                    if (!kb_valid || win_src == SRC_KB) starve_cnt <= '0;
                    else if (win_src == SRC_MIC && starve_cnt != STARVE_LIMIT)
                        starve_cnt <= starve_cnt + 1'b1;
                end
                OFFER: begin
                    if (out_retrieved) begin
                        out_valid <= 1'b0;
                        stall_cnt <= '0;
                    end else if (stall_cnt != STALL_MAX) begin
                        stall_cnt <= stall_cnt + 16'd1;
                        if (stall_cnt == STALL_MAX - 16'd1) stall_err <= 1'b1;
                    end
                end
                ACK:     grant_src <= SRC_NONE;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tx_packet_scheduler.sv
// Directed bench for tx_packet_scheduler: power reply, kb/mouse/mic packets, starvation order,
// power preemption, stall flag and reset mid-offer.
module tb_tx_packet_scheduler;

    localparam logic [39:0] PWR_PKT   = 40'hA5_1122_3344;
    localparam logic [7:0]  KB_OP     = 8'hC0;
    localparam logic [7:0]  MOUSE_OP  = 8'hD0;
    localparam logic [7:0]  MIC_OP    = 8'hE0;
    localparam int          KB_STARVE = 3;
    localparam logic [15:0] STALL_MAX = 16'd20;

    logic        mon_clk = 1'b0;
    logic        hw_reset_n;
    logic        pwr_req;
    logic        kb_valid;
    logic        kb_is_mouse;
    logic [15:0] kb_data;
    logic        kb_ack;
    logic        mic_valid;
    logic [31:0] mic_data;
    logic        mic_ack;
    logic [39:0] out_data;
    logic        out_valid;
    logic        out_retrieved;
    logic [1:0]  grant_src;
    logic        stall_err;

    int tests_run = 0;
    int tests_failed = 0;

    tx_packet_scheduler #(
        .PWR_PKT(PWR_PKT), .KB_OP(KB_OP), .MOUSE_OP(MOUSE_OP), .MIC_OP(MIC_OP),
        .KB_STARVE(KB_STARVE), .STALL_MAX(STALL_MAX)
    ) dut (
        .mon_clk(mon_clk), .hw_reset_n(hw_reset_n), .pwr_req(pwr_req),
        .kb_valid(kb_valid), .kb_is_mouse(kb_is_mouse), .kb_data(kb_data), .kb_ack(kb_ack),
        .mic_valid(mic_valid), .mic_data(mic_data), .mic_ack(mic_ack),
        .out_data(out_data), .out_valid(out_valid), .out_retrieved(out_retrieved),
        .grant_src(grant_src), .stall_err(stall_err)
    );

    always #5 mon_clk = ~mon_clk;

    // Inputs change and outputs are observed on the falling edge, clear of the active edge.
    task automatic applyStimulus(input int cycles);
        repeat (cycles) @(negedge mon_clk);
    endtask

    task automatic checkOutput(input string tag, input logic [39:0] observed, input logic [39:0] expected);
        tests_run++;
        assert (observed === expected)
        else begin
            tests_failed++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    task automatic retrieve();
        out_retrieved = 1'b1;
        applyStimulus(1);
        out_retrieved = 1'b0;
    endtask

    logic [1:0]  starve_order [8] = '{2'd3, 2'd3, 2'd3, 2'd2, 2'd3, 2'd3, 2'd3, 2'd2};
    logic [39:0] exp_pkt;

    initial begin
        hw_reset_n = 1'b0; pwr_req = 1'b0; kb_valid = 1'b0; kb_is_mouse = 1'b0;
        kb_data = '0; mic_valid = 1'b0; mic_data = '0; out_retrieved = 1'b0;
        applyStimulus(2);
        checkOutput("rst_valid", {39'd0, out_valid}, 40'd0);
        checkOutput("rst_data", out_data, 40'd0);
        checkOutput("rst_grant", {38'd0, grant_src}, 40'd0);
        checkOutput("rst_acks", {38'd0, kb_ack, mic_ack}, 40'd0);
        checkOutput("rst_stall", {39'd0, stall_err}, 40'd0);
        hw_reset_n = 1'b1;
        applyStimulus(1);

        // Power-on reply
        pwr_req = 1'b1;
        applyStimulus(1);
        pwr_req = 1'b0;
        checkOutput("pwr_valid", {39'd0, out_valid}, 40'd1);
        checkOutput("pwr_data", out_data, PWR_PKT);
        checkOutput("pwr_grant", {38'd0, grant_src}, 40'd1);
        applyStimulus(3);
        checkOutput("pwr_hold", {39'd0, out_valid}, 40'd1);
        retrieve();
        checkOutput("pwr_ack_state", {37'd0, out_valid, kb_ack, mic_ack}, 40'd0);
        applyStimulus(2);
        checkOutput("pwr_no_repeat", {37'd0, out_valid, grant_src}, 40'd0);

        // Keyboard then mouse
        kb_valid = 1'b1; kb_is_mouse = 1'b0; kb_data = 16'h1234;
        applyStimulus(1);
        checkOutput("kb_data", out_data, 40'hC0_0000_1234);
        checkOutput("kb_grant", {38'd0, grant_src}, 40'd2);
        checkOutput("kb_no_early_ack", {39'd0, kb_ack}, 40'd0);
        retrieve();
        checkOutput("kb_ack", {38'd0, kb_ack, mic_ack}, 40'h2);
        kb_valid = 1'b0;
        applyStimulus(1);
        checkOutput("kb_ack_once", {38'd0, kb_ack, out_valid}, 40'd0);
        kb_valid = 1'b1; kb_is_mouse = 1'b1; kb_data = 16'hABCD;
        applyStimulus(1);
        checkOutput("mouse_data", out_data, 40'hD0_0000_ABCD);
        retrieve();
        checkOutput("mouse_ack", {39'd0, kb_ack}, 40'd1);
        kb_valid = 1'b0; kb_is_mouse = 1'b0;
        applyStimulus(1);

        // Both held: keyboard forced in after three consecutive mic grants
        kb_valid = 1'b1; kb_data = 16'h0042;
        mic_valid = 1'b1; mic_data = 32'hDEAD_BEEF;
        applyStimulus(1);
        for (int i = 0; i < 8; i++) begin
            checkOutput($sformatf("starve_valid%0d", i), {39'd0, out_valid}, 40'd1);
            checkOutput($sformatf("starve_grant%0d", i), {38'd0, grant_src}, {38'd0, starve_order[i]});
            exp_pkt = (starve_order[i] == 2'd3) ? 40'hE0_DEAD_BEEF : 40'hC0_0000_0042;
            checkOutput($sformatf("starve_data%0d", i), out_data, exp_pkt);
            retrieve();
            if (i == 7) begin
                kb_valid = 1'b0;
                mic_valid = 1'b0;
            end
            applyStimulus(2);
        end
        checkOutput("starve_idle", {39'd0, out_valid}, 40'd0);

        // Power request arriving during a mic offer goes next
        kb_valid = 1'b1; kb_data = 16'h0077;
        mic_valid = 1'b1; mic_data = 32'h0102_0304;
        applyStimulus(1);
        checkOutput("pre_mic_grant", {38'd0, grant_src}, 40'd3);
        pwr_req = 1'b1;
        applyStimulus(1);
        pwr_req = 1'b0;
        checkOutput("pre_mic_kept", out_data, 40'hE0_0102_0304);
        retrieve();
        checkOutput("pre_mic_ack", {38'd0, kb_ack, mic_ack}, 40'd1);
        applyStimulus(2);
        checkOutput("pre_pwr_grant", {38'd0, grant_src}, 40'd1);
        checkOutput("pre_pwr_data", out_data, PWR_PKT);
        retrieve();
        checkOutput("pre_pwr_noack", {38'd0, kb_ack, mic_ack}, 40'd0);
        applyStimulus(2);
        checkOutput("pre_mic2_grant", {38'd0, grant_src}, 40'd3);
        retrieve();
        mic_valid = 1'b0;
        applyStimulus(2);
        checkOutput("pre_kb_grant", {38'd0, grant_src}, 40'd2);
        retrieve();
        kb_valid = 1'b0;
        applyStimulus(1);

        // Stall flag: set while unretrieved, sticky after completion
        kb_valid = 1'b1; kb_data = 16'h5555;
        applyStimulus(1);
        applyStimulus(5);
        checkOutput("stall_early", {39'd0, stall_err}, 40'd0);
        applyStimulus(30);
        checkOutput("stall_set", {39'd0, stall_err}, 40'd1);
        checkOutput("stall_still_valid", {39'd0, out_valid}, 40'd1);
        checkOutput("stall_data", out_data, 40'hC0_0000_5555);
        retrieve();
        checkOutput("stall_ack", {39'd0, kb_ack}, 40'd1);
        kb_valid = 1'b0;
        applyStimulus(2);
        checkOutput("stall_sticky", {39'd0, stall_err}, 40'd1);

        // Retrieved outside an offer does nothing
        out_retrieved = 1'b1;
        applyStimulus(2);
        out_retrieved = 1'b0;
        checkOutput("stray_retrieve", {37'd0, out_valid, kb_ack, mic_ack}, 40'd0);

        // Reset mid-offer drops the packet, then the still-valid source is re-offered
        kb_valid = 1'b1; kb_data = 16'h7777;
        applyStimulus(1);
        checkOutput("rmo_offer", {39'd0, out_valid}, 40'd1);
        hw_reset_n = 1'b0;
        applyStimulus(1);
        checkOutput("rmo_drop", {35'd0, out_valid, kb_ack, grant_src, stall_err}, 40'd0);
        hw_reset_n = 1'b1;
        applyStimulus(1);
        checkOutput("rmo_reoffer", {38'd0, grant_src}, 40'd2);
        checkOutput("rmo_data", out_data, 40'hC0_0000_7777);
        retrieve();
        checkOutput("rmo_ack", {39'd0, kb_ack}, 40'd1);
        kb_valid = 1'b0;
        applyStimulus(2);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
